// File: rtl/multdiv_unit.sv
// multdiv_unit: signed radix-2 Booth multiply and restoring divide; result WIDTH+1 cycles after start.
// Starts while busy are dropped, not queued. MULTDIV_DIV_EN compiles in the divide datapath.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int              CW    = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   ITERS = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DONE = 2'd2
`ifdef MULTDIV_DIV_EN
        , S_DIV = 2'd3
`endif
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH:0]   acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic               ill_q;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;
    logic               rdy_q;
    logic               start_ill;

    logic [WIDTH:0]     hi_ext;
    logic [WIDTH:0]     mc_ext;
    logic [WIDTH:0]     booth_sum;
    logic [2*WIDTH:0]   mult_d;
    logic               mult_ovf;

    // The upper accumulator is summed at WIDTH+1 bits so the shifted-in sign
    // stays correct even when the multiplicand is the most-negative value.
    always_comb begin
        hi_ext = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
        mc_ext = {mcand_q[WIDTH-1], mcand_q};
        case (acc_q[1:0])
            2'b01:   booth_sum = hi_ext + mc_ext;
            2'b10:   booth_sum = hi_ext - mc_ext;
            default: booth_sum = hi_ext;
        endcase
        mult_d   = {booth_sum, acc_q[WIDTH:1]};
        mult_ovf = !((&acc_q[2*WIDTH:WIDTH]) || !(|acc_q[2*WIDTH:WIDTH]));
    end

`ifdef MULTDIV_DIV_EN
    logic               neg_q;
    logic               dz_q;
    logic               dovf_q;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     div_rs;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH:0]   div_d;
    logic [WIDTH-1:0]   quot;

    // acc_q holds {remainder[WIDTH:0], quotient/dividend[WIDTH-1:0]} while dividing.
    always_comb begin
        abs_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        abs_b    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        div_rs   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_rs - {1'b0, mcand_q};
        if (div_diff[WIDTH]) begin
            div_d = {div_rs, acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
        end
        quot = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end

    assign start_ill = ctrl_MULT & ctrl_DIV;
`else
    assign start_ill = ctrl_DIV;
`endif

    always_comb begin
        busy = (state_q == S_MULT);
`ifdef MULTDIV_DIV_EN
        if (state_q == S_DIV) begin
            busy = 1'b1;
        end
`endif
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

    // Illegal requests spend one cycle in MULT with the counter preset to the
    // end, so they report through the same completion path one edge later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            ill_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
`ifdef MULTDIV_DIV_EN
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            dovf_q   <= 1'b0;
`endif
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ill) begin
                        state_q <= S_MULT;
                        cnt_q   <= ITERS;
                        ill_q   <= 1'b1;
                    end else if (ctrl_MULT) begin
                        state_q <= S_MULT;
                        cnt_q   <= '0;
                        ill_q   <= 1'b0;
                        mcand_q <= data_operandA;
                        acc_q   <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
`ifdef MULTDIV_DIV_EN
                    end else if (ctrl_DIV) begin
                        state_q <= S_DIV;
                        cnt_q   <= '0;
                        mcand_q <= abs_b;
                        acc_q   <= {{(WIDTH+1){1'b0}}, abs_a};
                        neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        dz_q    <= (data_operandB == '0);
                        dovf_q  <= (data_operandA == MIN_VAL) && (data_operandB == '1);
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_MULT: begin
                    if (cnt_q != ITERS) begin
                        acc_q <= mult_d;
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        state_q  <= S_DONE;
                        rdy_q    <= 1'b1;
                        result_q <= ill_q ? '0 : acc_q[WIDTH:1];
                        exc_q    <= ill_q | mult_ovf;
                    end
                end
`ifdef MULTDIV_DIV_EN
                S_DIV: begin
                    if (cnt_q != ITERS) begin
                        acc_q <= div_d;
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        state_q  <= S_DONE;
                        rdy_q    <= 1'b1;
                        result_q <= dz_q ? '0 : quot;
                        exc_q    <= dz_q | dovf_q;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit at WIDTH=32; divide expectations follow MULTDIV_DIV_EN.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    // Called #1 after a rising edge; returns #1 after the edge that raised ready.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic m, input logic d,
                         output logic [31:0] res, output logic exc, output int lat, output int bcnt);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = m;
        ctrl_DIV  = d;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (data_resultRDY !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clock); #1;
            lat++;
        end
        res = data_result;
        exc = data_exception;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", data_result); end
        checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc got %b want 0", data_exception); end
        checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_mult();
        logic [31:0] va [6] = '{32'd7, 32'h0001_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd12345};
        logic [31:0] vb [6] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] vr [6] = '{32'hFFFF_FFEB, 32'h0, 32'd1, 32'h8000_0000, 32'h8000_0000, 32'h0};
        logic        ve [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          bcnt;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], 1'b1, 1'b0, res, exc, lat, bcnt);
            checks++; if (res !== vr[i]) begin errors++; $display("FAIL mult_result[%0d] got %h want %h", i, res, vr[i]); end
            checks++; if (exc !== ve[i]) begin errors++; $display("FAIL mult_exc[%0d] got %b want %b", i, exc, ve[i]); end
            if (i == 0) begin
                checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d want 33", lat); end
                checks++; if (bcnt !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d want 33", bcnt); end
            end
            repeat (2) @(posedge clock);
            #1;
        end
    endtask

    task automatic test_pulse_hold();
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          bcnt;
        do_op(32'd6, 32'd7, 1'b1, 1'b0, res, exc, lat, bcnt);
        @(posedge clock); #1;
        checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL rdy_one_cycle got %b want 0", data_resultRDY); end
        repeat (3) @(posedge clock);
        #1;
        checks++; if (data_result !== 32'd42) begin errors++; $display("FAIL result_hold got %h want 0000002a", data_result); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        data_operandA = 32'd100;
        data_operandB = 32'd3;
        ctrl_MULT = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        checks++; if (data_result !== 32'd42) begin errors++; $display("FAIL hold_at_start got %h want 0000002a", data_result); end
        lat = 0;
        while (data_resultRDY !== 1'b1 && lat < 100) begin
            if (lat == 5) begin
                data_operandA = 32'd2;
                data_operandB = 32'd2;
                ctrl_MULT = 1'b1;
            end else begin
                ctrl_MULT = 1'b0;
            end
            @(posedge clock); #1;
            lat++;
        end
        ctrl_MULT = 1'b0;
        checks++; if (lat !== 33) begin errors++; $display("FAIL ignore_latency got %0d want 33", lat); end
        checks++; if (data_result !== 32'd300) begin errors++; $display("FAIL ignore_result got %h want 0000012c", data_result); end
        repeat (2) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_not_queued busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          bcnt;
        do_op(32'd9, 32'd9, 1'b1, 1'b0, res, exc, lat, bcnt);
        do_op(32'd12, 32'hFFFF_FFF4, 1'b1, 1'b0, res, exc, lat, bcnt);
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
        checks++; if (res !== 32'hFFFF_FF70) begin errors++; $display("FAIL b2b_result got %h want ffffff70", res); end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_illegal();
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          bcnt;
        do_op(32'd5, 32'd6, 1'b1, 1'b1, res, exc, lat, bcnt);
        checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency got %0d want 1", lat); end
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL illegal_result got %h want 00000000", res); end
        checks++; if (exc !== 1'b1) begin errors++; $display("FAIL illegal_exc got %b want 1", exc); end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_div();
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          bcnt;
`ifdef MULTDIV_DIV_EN
        logic [31:0] va [6] = '{32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000, 32'd7, 32'hFFFF_FF9C};
        logic [31:0] vb [6] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFF9};
        logic [31:0] vr [6] = '{32'hFFFF_FFFD, 32'd14, 32'h0, 32'h8000_0000, 32'hFFFF_FFFD, 32'd14};
        logic        ve [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], 1'b0, 1'b1, res, exc, lat, bcnt);
            checks++; if (res !== vr[i]) begin errors++; $display("FAIL div_result[%0d] got %h want %h", i, res, vr[i]); end
            checks++; if (exc !== ve[i]) begin errors++; $display("FAIL div_exc[%0d] got %b want %b", i, exc, ve[i]); end
            checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency[%0d] got %0d want 33", i, lat); end
            repeat (2) @(posedge clock);
            #1;
        end
`else
        do_op(32'd100, 32'd7, 1'b0, 1'b1, res, exc, lat, bcnt);
        checks++; if (lat !== 1) begin errors++; $display("FAIL nodiv_latency got %0d want 1", lat); end
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL nodiv_result got %h want 00000000", res); end
        checks++; if (exc !== 1'b1) begin errors++; $display("FAIL nodiv_exc got %b want 1", exc); end
        repeat (2) @(posedge clock);
        #1;
`endif
    endtask

    task automatic test_reset_midop();
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          bcnt;
        int          rdy_seen;
        do_op(32'h0001_0000, 32'h0001_0001, 1'b1, 1'b0, res, exc, lat, bcnt);
        data_operandA = 32'd3;
        data_operandB = 32'd3;
        ctrl_MULT = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy got %b want 1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL midop_result got %h want 00000000", data_result); end
        checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL midop_exc got %b want 0", data_exception); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midop_busy_clear got %b want 0", busy); end
        @(posedge clock); #1;
        reset = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY === 1'b1 || busy === 1'b1) rdy_seen++;
        end
        checks++; if (rdy_seen !== 0) begin errors++; $display("FAIL midop_no_ready got %0d active cycles want 0", rdy_seen); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_pulse_hold();
        test_busy_ignore();
        test_back_to_back();
        test_illegal();
        test_div();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
